ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Responder end of the processor's RAM1 request/MFC interface: a word-addressable register-file RAM with programmable wait states.
- Latches a request on Out_Enable and waits WAIT_CYCLES.
- Performs the read or write, then asserts MFC (memory function complete) until the processor drops Out_Enable.
- Sits between the processor's RAM1 port and on-chip storage; usable as a stand-in for the memory interface's RAM side.

Parameters:
DATA_W, 32, data word width
ADDR_W, 8, implemented address bits; depth = 2^ADDR_W words
WAIT_CYCLES, 2, wait-state count before completion, legal 0..15

Ports:
Clock  input  1  single clock, rising edge
Reset_L  input  1  asynchronous active-low reset
RAM1_Address  input  32  word address
RAM1_Read_H_Write_L  input  1  1 = read, 0 = write
RAM1_Out_Enable  input  1  request strobe, held high by processor until MFC seen
RAM1_Data_In  input  DATA_W  write data
RAM1_Data_Out  output  DATA_W  read data, valid while MFC=1
RAM1_MFC  output  1  completion flag
Busy  output  1  high in WAIT or DONE

Behaviour:
- Clocking and reset: one clock. Reset_L is asynchronous and active-low.
- Reset values: state=IDLE, RAM1_MFC=0, RAM1_Data_Out=0, Busy=0, wait counter=0. Storage contents are not reset (undefined at power-up).
- State machine: IDLE, WAIT, DONE (2-bit encoding); wait counter is 4 bits.
- IDLE:
  - On an edge with Out_Enable=1: latch address, direction and Data_In; load counter=WAIT_CYCLES; go to WAIT.
  - Otherwise stay.
- WAIT:
  - If Out_Enable=0 at an edge: abort to IDLE; no write, MFC stays 0.
  - Else if counter==0: go to DONE and perform the access in the same edge.
    - Write: mem[addr] <= latched data.
    - Read: RAM1_Data_Out <= mem[addr].
    - Set MFC=1.
  - Else decrement counter.
- DONE:
  - MFC=1 while Out_Enable=1.
  - On an edge with Out_Enable=0: MFC<=0, go to IDLE.
  - A new request needs Out_Enable low for at least one edge (no back-to-back without deassertion).
- Latency: request sampled at edge k gives MFC=1 after edge k+WAIT_CYCLES+1. WAIT_CYCLES=0 gives 1-edge latency.
- Latching: address, direction and data changes after the sampling edge are ignored for that transaction.
- RAM1_Data_Out: updated only on read completion; holds its value through writes and idle periods.
- Out-of-range access (RAM1_Address[31:ADDR_W] != 0):
  - Read returns 0; write is discarded.
  - MFC handshake is unchanged.
- Address wrap: none; only in-range bits index storage.
- Reset mid-operation: immediate return to IDLE with MFC=0. An in-flight write not yet at DONE is not performed.
- Busy=1 in WAIT and DONE, 0 in IDLE.

Optional Feature:
- Macro: RAM_RESPONDER_OOR_ERR_EN.
- Defined:
  - Adds output port RAM1_Err (1 bit, reset 0).
  - RAM1_Err is set with MFC on entry to DONE when the latched address is out of range, and clears with MFC.
  - Out-of-range reads still return 0.
- Undefined: port absent; out-of-range accesses complete silently as described above.

Test Plan:
- Reset: assert Reset_L=0 mid-clock -> MFC=0, Busy=0, Data_Out=0 immediately, without waiting for a clock edge.
- Write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to addr 0x05, Out_Enable at edge 0 -> MFC=1 after edge 3; drop Out_Enable -> MFC=0 after next edge.
  - Read addr 0x05 -> Data_Out=0xDEADBEEF with MFC after edge 3 of that request.
- Zero wait states (WAIT_CYCLES=0):
  - Read request at edge k -> MFC=1 after edge k+1.
  - Hold Out_Enable 5 extra cycles -> MFC stays 1 and Data_Out stays stable.
- Abort: write 0x12345678 to addr 0x10, drop Out_Enable after 1 cycle of WAIT -> MFC never rises; a following read of 0x10 returns the prior value.
- Out-of-range: write 0xAAAA5555 to addr 0x100 (ADDR_W=8), then read addr 0x100 and addr 0x00 -> read returns 0 and addr 0x00 is unchanged. With RAM_RESPONDER_OOR_ERR_EN defined, RAM1_Err=1 coincident with MFC.
- Reset mid-WAIT: write to addr 0x03, pull Reset_L low during WAIT, release, then read 0x03 -> old contents; no MFC during the aborted request.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: responder side of the RAM1 request/MFC handshake.
// Word-addressable register-file RAM with WAIT_CYCLES programmable wait states.
// A request is latched when Out_Enable is sampled high. After the wait states
// the access is performed and MFC is raised. MFC stays high until Out_Enable drops.
// Optional macro RAM_RESPONDER_OOR_ERR_EN adds the RAM1_Err output. RAM1_Err
// flags completion of an out-of-range access.
//
// state  | meaning
// IDLE   | no request in flight, waiting for Out_Enable
// WAIT   | request latched, counting down wait states
// DONE   | access performed, MFC held until Out_Enable drops
module ram_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic [31:0]       RAM1_Address,
  input  logic              RAM1_Read_H_Write_L,
  input  logic              RAM1_Out_Enable,
  input  logic [DATA_W-1:0] RAM1_Data_In,
  output logic [DATA_W-1:0] RAM1_Data_Out,
  output logic              RAM1_MFC,
  output logic              Busy
`ifdef RAM_RESPONDER_OOR_ERR_EN
  ,
  output logic              RAM1_Err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                oor_q;
  logic                rd_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic                oor_in;
  logic                complete;
  logic                mem_we;

  // Upper address bits select nothing. Any set bit marks the request out of range.
  assign oor_in   = |RAM1_Address[31:ADDR_W];
  assign complete = (state == S_WAIT) && RAM1_Out_Enable && (wait_cnt == 4'd0);
  assign mem_we   = complete && !rd_q && !oor_q;

  // Storage is never reset. The write happens on the WAIT->DONE edge.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

  // Handshake FSM with registered MFC, Busy and read data.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state         <= S_IDLE;
      wait_cnt      <= 4'd0;
      addr_q        <= '0;
      oor_q         <= 1'b0;
      rd_q          <= 1'b0;
      data_q        <= '0;
      RAM1_Data_Out <= '0;
      RAM1_MFC      <= 1'b0;
      Busy          <= 1'b0;
`ifdef RAM_RESPONDER_OOR_ERR_EN
      RAM1_Err      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (RAM1_Out_Enable) begin
            addr_q   <= RAM1_Address[ADDR_W-1:0];
            oor_q    <= oor_in;
            rd_q     <= RAM1_Read_H_Write_L;
            data_q   <= RAM1_Data_In;
            wait_cnt <= 4'(WAIT_CYCLES);
            state    <= S_WAIT;
            Busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!RAM1_Out_Enable) begin
            // Processor abandoned the request. No access takes place.
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else if (wait_cnt == 4'd0) begin
            state    <= S_DONE;
            RAM1_MFC <= 1'b1;
            if (rd_q) RAM1_Data_Out <= oor_q ? '0 : mem[addr_q];
`ifdef RAM_RESPONDER_OOR_ERR_EN
            RAM1_Err <= oor_q;
`endif
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!RAM1_Out_Enable) begin
            state    <= S_IDLE;
            RAM1_MFC <= 1'b0;
            Busy     <= 1'b0;
`ifdef RAM_RESPONDER_OOR_ERR_EN
            RAM1_Err <= 1'b0;
`endif
          end
        end
        default: begin
          state    <= S_IDLE;
          RAM1_MFC <= 1'b0;
          Busy     <= 1'b0;
`ifdef RAM_RESPONDER_OOR_ERR_EN
          RAM1_Err <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder. Instance 0 has WAIT_CYCLES=2 and instance 1 has WAIT_CYCLES=0.
// Each transaction pushes its expected read data to a queue. The value is popped
// and compared when MFC is observed.
module tb_ram_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr [2];
  logic        rw   [2];
  logic        oe   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        mfc  [2];
  logic        busy [2];
`ifdef RAM_RESPONDER_OOR_ERR_EN
  logic        err  [2];
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [int];
  logic [31:0] last_rd [2];
  logic [31:0] exp_q [$];

  ram_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .Clock(clk), .Reset_L(rst_n),
    .RAM1_Address(addr[0]), .RAM1_Read_H_Write_L(rw[0]),
    .RAM1_Out_Enable(oe[0]), .RAM1_Data_In(din[0]),
    .RAM1_Data_Out(dout[0]), .RAM1_MFC(mfc[0]), .Busy(busy[0])
`ifdef RAM_RESPONDER_OOR_ERR_EN
    , .RAM1_Err(err[0])
`endif
  );

  ram_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .Clock(clk), .Reset_L(rst_n),
    .RAM1_Address(addr[1]), .RAM1_Read_H_Write_L(rw[1]),
    .RAM1_Out_Enable(oe[1]), .RAM1_Data_In(din[1]),
    .RAM1_Data_Out(dout[1]), .RAM1_MFC(mfc[1]), .Busy(busy[1])
`ifdef RAM_RESPONDER_OOR_ERR_EN
    , .RAM1_Err(err[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One full handshake on instance s: request, wait for MFC, optional hold, release.
  task automatic req(input int s, input logic [31:0] a, input logic r,
                     input logic [31:0] d, input int hold);
    int          n;
    int          lat;
    logic        oor;
    logic [31:0] expv;
    lat = (s == 0) ? 4 : 2;
    oor = (a[31:8] != 24'd0);
    @(negedge clk);
    addr[s] = a; rw[s] = r; din[s] = d; oe[s] = 1'b1;
    if (r) begin
      expv = oor ? 32'd0 : model[int'(a)];
      last_rd[s] = expv;
    end else begin
      expv = last_rd[s];
      if (!oor) model[int'(a)] = d;
    end
    exp_q.push_back(expv);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        // Latched request must ignore later changes on the bus.
        addr[s] = ~a; din[s] = ~d; rw[s] = ~r;
      end
      if (mfc[s] === 1'b1) break;
    end
    check($sformatf("mfc_seen[%0d]", s), {63'd0, mfc[s]}, 64'd1);
    check($sformatf("latency[%0d]", s), 64'(n), 64'(lat));
    check($sformatf("busy_done[%0d]", s), {63'd0, busy[s]}, 64'd1);
    check($sformatf("data_out[%0d] a=%h", s, a), {32'd0, dout[s]}, {32'd0, exp_q.pop_front()});
`ifdef RAM_RESPONDER_OOR_ERR_EN
    check($sformatf("err[%0d]", s), {63'd0, err[s]}, {63'd0, oor});
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_mfc[%0d]", s), {63'd0, mfc[s]}, 64'd1);
      check($sformatf("hold_data[%0d]", s), {32'd0, dout[s]}, {32'd0, expv});
    end
    @(negedge clk);
    oe[s] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("mfc_drop[%0d]", s), {63'd0, mfc[s]}, 64'd0);
    check($sformatf("busy_drop[%0d]", s), {63'd0, busy[s]}, 64'd0);
    check($sformatf("data_keep[%0d]", s), {32'd0, dout[s]}, {32'd0, expv});
`ifdef RAM_RESPONDER_OOR_ERR_EN
    check($sformatf("err_drop[%0d]", s), {63'd0, err[s]}, 64'd0);
`endif
  endtask

  initial begin
    logic seen;
    for (int s = 0; s < 2; s++) begin
      addr[s] = 32'd0; rw[s] = 1'b1; oe[s] = 1'b0; din[s] = 32'd0; last_rd[s] = 32'd0;
    end
    rst_n = 1'b1;

    // Asynchronous reset mid-clock: outputs must clear without an edge.
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_mfc[%0d]", s), {63'd0, mfc[s]}, 64'd0);
      check($sformatf("rst_busy[%0d]", s), {63'd0, busy[s]}, 64'd0);
      check($sformatf("rst_dout[%0d]", s), {32'd0, dout[s]}, 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Write then read with two wait states.
    req(0, 32'h05, 1'b0, 32'hDEADBEEF, 0);
    req(0, 32'h05, 1'b1, 32'h0, 0);

    // An aborted write leaves the old contents in place.
    req(0, 32'h10, 1'b0, 32'h00000011, 0);
    @(negedge clk);
    addr[0] = 32'h10; rw[0] = 1'b0; din[0] = 32'h12345678; oe[0] = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1; seen |= mfc[0];
    @(posedge clk); #1; seen |= mfc[0];
    @(negedge clk); oe[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; seen |= mfc[0];
    end
    check("abort_no_mfc", {63'd0, seen}, 64'd0);
    check("abort_idle", {63'd0, busy[0]}, 64'd0);
    req(0, 32'h10, 1'b1, 32'h0, 0);

    // Out-of-range write is discarded and reads back as zero.
    req(0, 32'h00, 1'b0, 32'h01234567, 0);
    req(0, 32'h100, 1'b0, 32'hAAAA5555, 0);
    req(0, 32'h100, 1'b1, 32'h0, 0);
    req(0, 32'h00, 1'b1, 32'h0, 0);

    // Reset during WAIT drops the in-flight write.
    req(0, 32'h03, 1'b0, 32'hCAFEF00D, 0);
    @(negedge clk);
    addr[0] = 32'h03; rw[0] = 1'b0; din[0] = 32'h0BADBEEF; oe[0] = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_busy", {63'd0, busy[0]}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_mfc", {63'd0, mfc[0]}, 64'd0);
    check("rst_wait_busy0", {63'd0, busy[0]}, 64'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    oe[0] = 1'b0;
    rst_n = 1'b1;
    req(0, 32'h03, 1'b1, 32'h0, 0);

    // Zero wait states, including a long hold and the top address.
    req(1, 32'h07, 1'b0, 32'h00005A5A, 0);
    req(1, 32'h07, 1'b1, 32'h0, 5);
    req(1, 32'hFF, 1'b0, 32'hFFFFFFFF, 0);
    req(1, 32'hFF, 1'b1, 32'h0, 0);
    req(1, 32'h07, 1'b1, 32'h0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
